// File: rtl/sw_max_tracker.sv
// sw_max_tracker: running maximum (score, PE, diagonal, re_pos) over one systolic alignment pass
module sw_max_tracker #(
    parameter int NUM_PE   = 8,
    parameter int SCORE_W  = 8,
    parameter int POS_W    = 3,
    parameter int NUM_DIAG = 15,
    parameter int CYC_W    = 5,
    parameter int PE_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [NUM_PE*SCORE_W-1:0] scores_in,
    input  logic [NUM_PE*POS_W-1:0]   pos_in,
    output logic                      busy,
    output logic                      done,
    output logic [SCORE_W-1:0]        best_score,
    output logic [PE_W-1:0]           best_pe,
    output logic [CYC_W-1:0]          best_diag,
    output logic [POS_W-1:0]          best_re_pos
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_next;
    logic [CYC_W-1:0]   diag_cnt;
    logic               accept, last, clear;
    logic [SCORE_W-1:0] win_score, s1_score;
    logic [PE_W-1:0]    win_pe, s1_pe;
    logic [POS_W-1:0]   win_pos, s1_pos;
    logic [CYC_W-1:0]   s1_diag;
    logic               s1_valid;

    assign accept = (state == RUN) && in_valid;
    assign last   = diag_cnt == CYC_W'(NUM_DIAG - 1);
    assign clear  = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN) || (state == FLUSH);
    assign done   = state == DONE;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state: a pass ends after the last diagonal drains through stage 2
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (accept && last) ? FLUSH : RUN;
            FLUSH:   state_next = DONE;
            default: state_next = start ? RUN : IDLE;
        endcase
    end

    // beat winner: strict compare scanning upward keeps the lowest PE on ties
    always_comb begin
        win_score = scores_in[0 +: SCORE_W];
        win_pe    = '0;
        win_pos   = pos_in[0 +: POS_W];
        for (int i = 1; i < NUM_PE; i++) begin
            if (scores_in[i*SCORE_W +: SCORE_W] > win_score) begin
                win_score = scores_in[i*SCORE_W +: SCORE_W];
                win_pe    = PE_W'(i);
                win_pos   = pos_in[i*POS_W +: POS_W];
            end
        end
    end

    // diagonal counter: stalls on gaps and parks at the last diagonal
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                diag_cnt <= '0;
        else if (clear)           diag_cnt <= '0;
        else if (accept && !last) diag_cnt <= diag_cnt + CYC_W'(1);
    end

    // stage 1: register the beat winner with its diagonal index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_score <= '0;
            s1_pe    <= '0;
            s1_pos   <= '0;
            s1_diag  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_score <= win_score;
                s1_pe    <= win_pe;
                s1_pos   <= win_pos;
                s1_diag  <= diag_cnt;
            end
        end
    end

    // stage 2: strictly-greater fold keeps the earliest diagonal and ignores zero scores
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            best_score  <= '0;
            best_pe     <= '0;
            best_diag   <= '0;
            best_re_pos <= '1;
        end else if (s1_valid && s1_score > best_score) begin
            best_score  <= s1_score;
            best_pe     <= s1_pe;
            best_diag   <= s1_diag;
            best_re_pos <= s1_pos;
        end
    end
endmodule

// File: tb/tb_sw_max_tracker.sv
// tb_sw_max_tracker: directed table-driven checks of the alignment maximum tracker
module tb_sw_max_tracker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] scores_in = '0;
    logic [23:0] pos_in = '0;
    logic        busy, done;
    logic [7:0]  best_score;
    logic [2:0]  best_pe;
    logic [4:0]  best_diag;
    logic [2:0]  best_re_pos;
    int tests = 0;
    int failed = 0;

    typedef struct {
        string name;
        int hd, hp, hs, hpos, bg;
        int es, ep, ed, epos;
    } vec_t;

    sw_max_tracker dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .scores_in(scores_in), .pos_in(pos_in), .busy(busy), .done(done),
        .best_score(best_score), .best_pe(best_pe), .best_diag(best_diag),
        .best_re_pos(best_re_pos)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // 15 beats: one hot cell over a bounded background pattern
    task automatic send_beats(input vec_t r, input int gap, input int mid_start);
        for (int d = 0; d < 15; d++) begin
            for (int p = 0; p < 8; p++) begin
                scores_in[p*8 +: 8] = (d == r.hd && p == r.hp) ? 8'(r.hs) :
                                      (r.bg == 0) ? 8'd0 : 8'((d*3 + p*5) % r.bg);
                pos_in[p*3 +: 3]    = (d == r.hd && p == r.hp) ? 3'(r.hpos) : 3'((d + p) % 8);
            end
            in_valid = 1'b1;
            start = (d == mid_start);
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
            if (d < 14) repeat (gap) begin
                check({r.name, " gap no done"}, 32'(done), 0);
                @(negedge clk);
            end
        end
    endtask

    task automatic finish_pass(input vec_t r);
        check({r.name, " flush busy"}, 32'(busy), 1);
        check({r.name, " flush done"}, 32'(done), 0);
        @(negedge clk);
        check({r.name, " done"}, 32'(done), 1);
        check({r.name, " score"}, 32'(best_score), r.es);
        check({r.name, " pe"}, 32'(best_pe), r.ep);
        check({r.name, " diag"}, 32'(best_diag), r.ed);
        check({r.name, " re_pos"}, 32'(best_re_pos), r.epos);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t r;
        tbl[0] = '{"all_zero", 0, 0, 0, 0, 0, 0, 0, 0, 7};
        tbl[1] = '{"hot_mid", 6, 3, 40, 2, 40, 40, 3, 6, 2};
        tbl[2] = '{"first_cell_max", 0, 0, 255, 5, 255, 255, 0, 0, 5};
        tbl[3] = '{"last_cell", 14, 7, 200, 1, 100, 200, 7, 14, 1};
        tbl[4] = '{"score_one", 10, 4, 1, 6, 0, 1, 4, 10, 6};

        // reset values
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset score", 32'(best_score), 0);
        check("reset re_pos", 32'(best_re_pos), 7);
        reset = 1'b0;
        @(negedge clk);

        // T1: reset in the middle of a pass
        do_start();
        for (int d = 0; d < 5; d++) begin
            scores_in = '0;
            pos_in = '0;
            if (d == 0) begin
                scores_in[15:8] = 8'd50;
                pos_in[5:3] = 3'd2;
            end
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("midrun busy", 32'(busy), 1);
        check("midrun score", 32'(best_score), 50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post reset busy", 32'(busy), 0);
        check("post reset score", 32'(best_score), 0);
        check("post reset re_pos", 32'(best_re_pos), 7);
        @(negedge clk);

        // table passes (includes T2 all zero, T3 single hot cell)
        foreach (tbl[k]) begin
            do_start();
            send_beats(tbl[k], 0, -1);
            finish_pass(tbl[k]);
            @(negedge clk);
            check({tbl[k].name, " done drop"}, 32'(done), 0);
            check({tbl[k].name, " idle"}, 32'(busy), 0);
            check({tbl[k].name, " hold"}, 32'(best_score), tbl[k].es);
        end

        // T4: ties within a beat and across beats
        do_start();
        for (int d = 0; d < 15; d++) begin
            scores_in = '0;
            pos_in = '0;
            if (d == 4) begin
                scores_in[5*8 +: 8] = 8'd30; pos_in[5*3 +: 3] = 3'd3;
                scores_in[2*8 +: 8] = 8'd30; pos_in[2*3 +: 3] = 3'd1;
            end
            if (d == 9) begin
                scores_in[7:0] = 8'd30; pos_in[2:0] = 3'd4;
            end
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        r = '{"tie", 0, 0, 0, 0, 0, 30, 2, 4, 1};
        finish_pass(r);
        @(negedge clk);

        // T5: gapped stream, then stray beats in DONE and IDLE
        r = '{"gaps", 7, 6, 77, 3, 50, 77, 6, 7, 3};
        do_start();
        send_beats(r, 2, -1);
        finish_pass(r);
        scores_in = '1;
        pos_in = '0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("stray score", 32'(best_score), 77);
        check("stray diag", 32'(best_diag), 7);
        check("stray busy", 32'(busy), 0);

        // T6: start with in_valid in IDLE, start in RUN, back-to-back start in DONE
        scores_in = '1;
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        r = '{"pass1", 3, 2, 90, 4, 50, 90, 2, 3, 4};
        send_beats(r, 0, 5);
        finish_pass(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", 32'(busy), 1);
        check("b2b cleared", 32'(best_score), 0);
        r = '{"pass2", 11, 7, 12, 0, 10, 12, 7, 11, 0};
        send_beats(r, 0, -1);
        finish_pass(r);
        @(negedge clk);
        check("pass2 done drop", 32'(done), 0);
        check("pass2 idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
